// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency instruction memory
// over req/ready, and feeds decode. Optional perf counters under `FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             FU_CLK,
  input  logic             FU_RST,
  input  logic             FU_StallF,
  input  logic [1:0]       FU_PcSrc,
  input  logic [WIDTH-1:0] FU_PcBranchD,
  input  logic [WIDTH-1:0] FU_PcJumpD,
  input  logic [WIDTH-1:0] FU_IMemRdata,
  input  logic             FU_IMemReady,
  output logic             FU_IMemReq,
  output logic [WIDTH-1:0] FU_IMemAddr,
  output logic [WIDTH-1:0] FU_PCF,
  output logic [WIDTH-1:0] FU_PCPLUS4F,
  output logic [WIDTH-1:0] FU_InstrF,
  output logic             FU_InstrValidF
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]      FU_InstrCount,
  output logic [31:0]      FU_BubbleCount
`endif
);

  typedef enum logic [1:0] {RSTW, FETCH, HOLD} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_pcf, w_pcf_nxt;
  logic [WIDTH-1:0] r_buf, w_buf_nxt;
  logic             r_pending, w_pending_nxt;
  logic [WIDTH-1:0] r_pend_tgt, w_pend_tgt_nxt;

  logic [WIDTH-1:0] w_pcplus4;
  logic [WIDTH-1:0] w_sel_raw;
  logic [WIDTH-1:0] w_next_pc;
  logic             w_redirect;
  logic             w_live;
  logic             w_valid;

  assign w_pcplus4  = r_pcf + WIDTH'(4);
  // Jump beats branch when both bits are set.
  assign w_sel_raw  = FU_PcSrc[1] ? FU_PcJumpD :
                      FU_PcSrc[0] ? FU_PcBranchD : w_pcplus4;
  assign w_next_pc  = w_sel_raw & ~WIDTH'(3);
  assign w_redirect = ~FU_StallF & (|FU_PcSrc);
  assign w_live     = FU_IMemReady & ~r_pending;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned
  // (that would infer a latch).
  always_comb begin
    w_state_nxt    = r_state;
    w_pcf_nxt      = r_pcf;
    w_buf_nxt      = r_buf;
    w_pending_nxt  = r_pending;
    w_pend_tgt_nxt = r_pend_tgt;
    FU_IMemReq     = 1'b0;
    FU_InstrF      = '0;
    w_valid        = 1'b0;
    case (r_state)
      RSTW: w_state_nxt = FETCH;
      FETCH: begin
        FU_IMemReq = 1'b1;
        w_valid    = w_live;
        FU_InstrF  = w_live ? FU_IMemRdata : '0;
        if (FU_IMemReady) begin
          if (r_pending) begin
            // Wrong-path word returns: drop it and steer to the newest redirect.
            w_pcf_nxt     = w_redirect ? w_next_pc : r_pend_tgt;
            w_pending_nxt = 1'b0;
          end else if (!FU_StallF) begin
            w_pcf_nxt = w_next_pc;
          end else begin
            w_buf_nxt   = FU_IMemRdata;
            w_state_nxt = HOLD;
          end
        end else if (w_redirect) begin
          // The outstanding request cannot be aborted, so IMemAddr must stay put.
          w_pending_nxt  = 1'b1;
          w_pend_tgt_nxt = w_next_pc;
        end
      end
      HOLD: begin
        FU_InstrF = r_buf;
        w_valid   = 1'b1;
        if (!FU_StallF) begin
          w_pcf_nxt   = w_next_pc;
          w_state_nxt = FETCH;
        end
      end
      default: w_state_nxt = RSTW;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the instruction buffer is
  // reset as well so HOLD can never present stale data from before reset.
  always_ff @(posedge FU_CLK or negedge FU_RST) begin
    if (!FU_RST) begin
      r_state    <= RSTW;
      r_pcf      <= RESET_PC;
      r_buf      <= '0;
      r_pending  <= 1'b0;
      r_pend_tgt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pcf      <= w_pcf_nxt;
      r_buf      <= w_buf_nxt;
      r_pending  <= w_pending_nxt;
      r_pend_tgt <= w_pend_tgt_nxt;
    end
  end

  assign FU_IMemAddr    = r_pcf;
  assign FU_PCF         = r_pcf;
  assign FU_PCPLUS4F    = w_pcplus4;
  assign FU_InstrValidF = w_valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_instr_cnt, r_bubble_cnt;
  logic        w_cnt_instr, w_cnt_bubble;

  assign w_cnt_instr  = w_valid & ~FU_StallF & ~r_pending;
  assign w_cnt_bubble = (r_state == FETCH) & ~w_valid & ~FU_StallF;

  always_ff @(posedge FU_CLK or negedge FU_RST) begin
    if (!FU_RST) begin
      r_instr_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_cnt_instr && (r_instr_cnt != '1))   r_instr_cnt  <= r_instr_cnt + 32'd1;
      if (w_cnt_bubble && (r_bubble_cnt != '1)) r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign FU_InstrCount  = r_instr_cnt;
  assign FU_BubbleCount = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: hand-derived vector table, reset corner sequence, then random
// stimulus checked against a queue-based behavioural model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk, rst_n;
  logic        stall;
  logic [1:0]  pcsrc;
  logic [31:0] br_t, jp_t, rdata;
  logic        ready;
  logic        req, valid;
  logic [31:0] addr, pcf, pcp4, instr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] icnt, bcnt;
`endif

  fetch_unit #(.WIDTH(32), .RESET_PC(RST_PC)) dut (
    .FU_CLK(clk), .FU_RST(rst_n), .FU_StallF(stall), .FU_PcSrc(pcsrc),
    .FU_PcBranchD(br_t), .FU_PcJumpD(jp_t), .FU_IMemRdata(rdata),
    .FU_IMemReady(ready), .FU_IMemReq(req), .FU_IMemAddr(addr), .FU_PCF(pcf),
    .FU_PCPLUS4F(pcp4), .FU_InstrF(instr), .FU_InstrValidF(valid)
`ifdef FETCH_PERF_CNT_EN
    , .FU_InstrCount(icnt), .FU_BubbleCount(bcnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic st, input logic [1:0] src, input logic rdy,
                       input logic [31:0] rd, input logic [31:0] br, input logic [31:0] jp);
    stall = st; pcsrc = src; ready = rdy; rdata = rd; br_t = br; jp_t = jp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc;
  bit          m_started;
  logic [31:0] m_held[$];   // non-empty: a word is parked for decode
  logic [31:0] m_redir[$];  // non-empty: wrong-path request in flight, holds new target
  logic [31:0] m_icnt, m_bcnt;

  task automatic model_reset();
    m_pc = RST_PC; m_started = 0; m_held.delete(); m_redir.delete();
    m_icnt = 0; m_bcnt = 0;
  endtask

  task automatic model_expect(output logic e_req, output logic e_valid, output logic [31:0] e_instr);
    e_req = 0; e_valid = 0; e_instr = 0;
    if (m_started) begin
      if (m_held.size() != 0) begin
        e_valid = 1; e_instr = m_held[0];
      end else begin
        e_req = 1;
        e_valid = ready && (m_redir.size() == 0);
        e_instr = e_valid ? rdata : 32'h0;
      end
    end
  endtask

  task automatic model_update();
    logic [31:0] tgt;
    logic        redirect, e_req, e_valid;
    logic [31:0] e_instr;
    model_expect(e_req, e_valid, e_instr);
    if (e_valid && !stall && m_redir.size() == 0 && m_icnt != 32'hFFFF_FFFF) m_icnt++;
    if (e_req && !e_valid && !stall && m_bcnt != 32'hFFFF_FFFF) m_bcnt++;
    tgt = pcsrc[1] ? jp_t : (pcsrc[0] ? br_t : m_pc + 32'd4);
    tgt = {tgt[31:2], 2'b00};
    redirect = !stall && (pcsrc != 2'b00);
    if (!m_started) m_started = 1;
    else if (m_held.size() != 0) begin
      if (!stall) begin m_pc = tgt; m_held.delete(); end
    end else if (ready) begin
      if (m_redir.size() != 0) begin
        m_pc = redirect ? tgt : m_redir[0];
        m_redir.delete();
      end else if (!stall) m_pc = tgt;
      else m_held.push_back(rdata);
    end else if (redirect) begin
      m_redir.delete();
      m_redir.push_back(tgt);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        st;
    logic [1:0]  src;
    logic        rdy;
    logic [31:0] rd, br, jp;
    logic        e_req, e_valid;
    logic [31:0] e_instr, e_pcf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic st, input logic [1:0] src, input logic rdy, input logic [31:0] rd,
                     input logic [31:0] br, input logic [31:0] jp, input logic e_req,
                     input logic e_valid, input logic [31:0] e_instr, input logic [31:0] e_pcf);
    vec_t v;
    v.st = st; v.src = src; v.rdy = rdy; v.rd = rd; v.br = br; v.jp = jp;
    v.e_req = e_req; v.e_valid = e_valid; v.e_instr = e_instr; v.e_pcf = e_pcf;
    tbl.push_back(v);
  endtask

  task automatic do_reset_mid_cycle(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_rst_pcf"}, pcf, RST_PC);
    check({tag, "_rst_pcp4"}, pcp4, RST_PC + 32'd4);
    check({tag, "_rst_req"}, {31'b0, req}, 32'd0);
    check({tag, "_rst_valid"}, {31'b0, valid}, 32'd0);
    check({tag, "_rst_instr"}, instr, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  logic        e_req, e_valid;
  logic [31:0] e_instr;

  initial begin
    rst_n = 1'b0;
    apply(0, 2'b00, 1, 32'h0, 32'h0, 32'h0);
    model_reset();

    // Rows: stall, pcsrc, ready, rdata, branch, jump | req, valid, instr, pcf
    add(0, 2'b00, 1, 32'hA000, 0, 0, 0, 0, 32'h0, 32'h00);      // idle cycle after release
    add(0, 2'b00, 1, 32'hA001, 0, 0, 1, 1, 32'hA001, 32'h00);
    add(0, 2'b00, 1, 32'hA002, 0, 0, 1, 1, 32'hA002, 32'h04);
    add(0, 2'b00, 1, 32'hA003, 0, 0, 1, 1, 32'hA003, 32'h08);
    add(0, 2'b00, 1, 32'hA004, 0, 0, 1, 1, 32'hA004, 32'h0C);
    add(0, 2'b00, 0, 32'hB000, 0, 0, 1, 0, 32'h0, 32'h10);      // memory busy x3
    add(0, 2'b00, 0, 32'hB000, 0, 0, 1, 0, 32'h0, 32'h10);
    add(0, 2'b00, 0, 32'hB000, 0, 0, 1, 0, 32'h0, 32'h10);
    add(0, 2'b00, 1, 32'hB001, 0, 0, 1, 1, 32'hB001, 32'h10);
    add(0, 2'b00, 1, 32'hA005, 0, 0, 1, 1, 32'hA005, 32'h14);
    add(0, 2'b00, 1, 32'hA006, 0, 0, 1, 1, 32'hA006, 32'h18);
    add(0, 2'b00, 1, 32'hA007, 0, 0, 1, 1, 32'hA007, 32'h1C);
    add(1, 2'b00, 1, 32'hC000, 0, 0, 1, 1, 32'hC000, 32'h20);   // stall captures word
    add(1, 2'b01, 1, 32'hD000, 32'h300, 0, 0, 1, 32'hC000, 32'h20);
    add(1, 2'b00, 1, 32'hD001, 0, 0, 0, 1, 32'hC000, 32'h20);
    add(0, 2'b00, 1, 32'hD002, 0, 0, 0, 1, 32'hC000, 32'h20);
    add(0, 2'b00, 1, 32'hA008, 0, 0, 1, 1, 32'hA008, 32'h24);
    add(0, 2'b00, 1, 32'hA009, 0, 0, 1, 1, 32'hA009, 32'h28);
    add(0, 2'b00, 1, 32'hA00A, 0, 0, 1, 1, 32'hA00A, 32'h2C);
    add(0, 2'b01, 0, 32'hE000, 32'h100, 0, 1, 0, 32'h0, 32'h30); // branch while busy
    add(0, 2'b00, 1, 32'hE001, 0, 0, 1, 0, 32'h0, 32'h30);       // discarded
    add(0, 2'b11, 1, 32'hF000, 32'h200, 32'h400, 1, 1, 32'hF000, 32'h100);
    add(1, 2'b11, 1, 32'hF001, 32'h200, 32'h800, 1, 1, 32'hF001, 32'h400);
    add(1, 2'b11, 1, 32'hF002, 32'h200, 32'h800, 0, 1, 32'hF001, 32'h400);
    add(0, 2'b00, 1, 32'hF003, 0, 0, 0, 1, 32'hF001, 32'h400);
    add(0, 2'b01, 1, 32'hF004, 32'h503, 0, 1, 1, 32'hF004, 32'h404); // low bits dropped
    add(0, 2'b01, 0, 32'hF005, 32'h600, 0, 1, 0, 32'h0, 32'h500);
    add(0, 2'b10, 0, 32'hF006, 0, 32'h700, 1, 0, 32'h0, 32'h500);    // latest wins
    add(0, 2'b00, 1, 32'hF007, 0, 0, 1, 0, 32'h0, 32'h500);
    add(0, 2'b01, 0, 32'hF008, 32'h900, 0, 1, 0, 32'h0, 32'h700);
    add(0, 2'b10, 1, 32'hF009, 0, 32'hA00, 1, 0, 32'h0, 32'h700);    // override on return
    add(0, 2'b10, 1, 32'hF00A, 0, 32'hFFFF_FFFC, 1, 1, 32'hF00A, 32'hA00);
    add(0, 2'b00, 1, 32'hF00B, 0, 0, 1, 1, 32'hF00B, 32'hFFFF_FFFC); // wraps to 0
    add(0, 2'b00, 0, 32'hF00C, 0, 0, 1, 0, 32'h0, 32'h0);
    add(0, 2'b01, 0, 32'hF00D, 32'h800, 0, 1, 0, 32'h0, 32'h0);
    add(1, 2'b10, 1, 32'hF00E, 0, 32'h900, 1, 0, 32'h0, 32'h0);     // stall ignores jump
    add(0, 2'b00, 1, 32'hF00F, 0, 0, 1, 1, 32'hF00F, 32'h800);
    add(0, 2'b00, 1, 32'hF010, 0, 0, 1, 1, 32'hF010, 32'h804);

    #2;
    check("reset_pcf", pcf, RST_PC);
    check("reset_pcp4", pcp4, RST_PC + 32'd4);
    check("reset_req", {31'b0, req}, 32'd0);
    check("reset_valid", {31'b0, valid}, 32'd0);
    check("reset_instr", instr, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("reset_icnt", icnt, 32'd0);
    check("reset_bcnt", bcnt, 32'd0);
`endif
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].st, tbl[i].src, tbl[i].rdy, tbl[i].rd, tbl[i].br, tbl[i].jp);
      #2;
      check($sformatf("vec%0d_req", i), {31'b0, req}, {31'b0, tbl[i].e_req});
      check($sformatf("vec%0d_valid", i), {31'b0, valid}, {31'b0, tbl[i].e_valid});
      check($sformatf("vec%0d_instr", i), instr, tbl[i].e_instr);
      check($sformatf("vec%0d_pcf", i), pcf, tbl[i].e_pcf);
      check($sformatf("vec%0d_addr", i), addr, tbl[i].e_pcf);
      check($sformatf("vec%0d_pcp4", i), pcp4, tbl[i].e_pcf + 32'd4);
      tick();
    end

    // Reset while a wrong-path request is outstanding at 0x44.
    apply(0, 2'b10, 1, 32'h1234, 0, 32'h44);
    tick();
    apply(0, 2'b01, 0, 32'h1235, 32'h1000, 0);
    #1;
    check("midrst_pcf_before", pcf, 32'h44);
    tick();
    apply(0, 2'b00, 0, 32'h1236, 0, 0);
    #1;
    check("midrst_addr_stable", addr, 32'h44);
    do_reset_mid_cycle("midrst");
    apply(0, 2'b00, 1, 32'h5555, 0, 0);
    #2;
    check("midrst_idle_req", {31'b0, req}, 32'd0);
    tick();
    #2;
    check("midrst_first_valid", {31'b0, valid}, 32'd1);
    check("midrst_first_instr", instr, 32'h5555);
    check("midrst_first_pcf", pcf, RST_PC);
    tick();

    // Random phase against the model.
    do_reset_mid_cycle("rnd_start");
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] jr;
      jr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
      apply($urandom_range(0, 9) < 3, ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b00,
            $urandom_range(0, 9) < 7, $urandom, $urandom, jr);
      #2;
      model_expect(e_req, e_valid, e_instr);
      check("rnd_req", {31'b0, req}, {31'b0, e_req});
      check("rnd_valid", {31'b0, valid}, {31'b0, e_valid});
      check("rnd_instr", instr, e_instr);
      check("rnd_pcf", pcf, m_pc);
      check("rnd_pcp4", pcp4, m_pc + 32'd4);
`ifdef FETCH_PERF_CNT_EN
      check("rnd_icnt", icnt, m_icnt);
      check("rnd_bcnt", bcnt, m_bcnt);
`endif
      model_update();
      tick();
      if (c % 750 == 749) do_reset_mid_cycle("rnd_rst");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
